// File: rtl/uart_tx_ctrl_if.sv
// Data/serializer interface of the UART transmit frame sequencer.
// master: the side that requests bytes and hosts the serializer.
// slave: the frame sequencer.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  DATA_VALID;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  SER_DATA;
    logic                  SER_DONE;
    logic                  SER_EN;
    logic                  TX_OUT;
    logic                  BUSY;
    logic                  ERR;

    modport master (
        output DATA_VALID, P_DATA, PAR_EN, PAR_TYP, SER_DATA, SER_DONE,
        input  SER_EN, TX_OUT, BUSY, ERR
    );

    modport slave (
        input  DATA_VALID, P_DATA, PAR_EN, PAR_TYP, SER_DATA, SER_DONE,
        output SER_EN, TX_OUT, BUSY, ERR
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start bit, DATA_WIDTH data bits from the
// serializer, optional internally generated parity bit, stop bit.
// TX_OUT is registered and trails the state by one cycle.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input logic           CLK,
    input logic           RST,
    uart_tx_ctrl_if.slave bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             par_q;
    logic             par_en_q;
    logic             tx_q;
    logic             tx_d;
    logic             err_q;
    logic             guard;

    assign guard = (cnt_q == CNT_LAST);

    // Line level belonging to the current state, captured into tx_q next edge.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = bus.SER_DATA;
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    // Frame FSM with registered line, bit counter, parity latch and error flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            tx_q     <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            tx_q <= tx_d;
            case (state_q)
                IDLE: begin
                    if (bus.DATA_VALID) begin
                        par_q    <= (^bus.P_DATA) ^ bus.PAR_TYP;
                        par_en_q <= bus.PAR_EN;
                        state_q  <= START;
                    end
                end
                START: state_q <= DATA;
                DATA: begin
                    if (bus.SER_DONE || guard) begin
                        cnt_q <= '0;
                        if (!bus.SER_DONE) begin
                            err_q <= 1'b1;
                        end
                        state_q <= par_en_q ? PARITY : STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PARITY:  state_q <= STOP;
                STOP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.SER_EN = (state_q == DATA);
    assign bus.BUSY   = (state_q != IDLE);
    assign bus.TX_OUT = tx_q;
    assign bus.ERR    = err_q;
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmit path.
- Accepts a byte request, sequences the 8-bit serializer through start bit, data bits, optional parity bit and stop bit, and generates the parity bit internally.
- Drives the registered TX line.
- Sits between the UART_TX top-level data interface and the serializer, in the UART TX clock domain.

Parameters:
DATA_WIDTH, 8, data bits per frame; width of P_DATA and upper bound of the internal bit counter.

Ports:
CLK  in  1  UART TX clock
RST  in  1  reset, asynchronous, active-low
DATA_VALID  in  1  byte request; sampled only in IDLE
P_DATA  in  DATA_WIDTH  byte to send; used for parity only (the serializer holds the data)
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even, 1 = odd
SER_DATA  in  1  current serial bit from the serializer
SER_DONE  in  1  serializer flags that the bit now presented is the last data bit
SER_EN  out  1  shift enable to the serializer
TX_OUT  out  1  serial line, registered, idle high
BUSY  out  1  frame in progress
ERR  out  1  sticky: data phase ended by the bit-count guard, not by SER_DONE

Behaviour:
Reset (RST low, async):
- state = IDLE; TX_OUT = 1; SER_EN = 0; BUSY = 0; ERR = 0; bit counter = 0; parity register = 0.

States: IDLE, START, DATA, PARITY, STOP (binary encoded).
- IDLE -> START when DATA_VALID = 1. On the same edge, latch:
  - par_bit = ^P_DATA ^ PAR_TYP
  - PAR_EN
- START -> DATA unconditionally (1 cycle).
- DATA:
  - SER_EN = 1 (combinational, this state only); bit counter increments each cycle.
  - Exit when SER_DONE = 1, or when counter == DATA_WIDTH-1 (guard).
  - If the guard fires with SER_DONE = 0, set ERR (sticky until reset).
  - Exit goes to PARITY if latched PAR_EN = 1, else to STOP.
  - Counter clears on exit.
- PARITY -> STOP unconditionally (1 cycle).
- STOP -> IDLE unconditionally (1 cycle).

Request handling:
- DATA_VALID is ignored outside IDLE; no queuing.
- The earliest next acceptance is the cycle after STOP.
- PAR_EN, PAR_TYP and P_DATA changes after acceptance do not affect the current frame.

TX_OUT (registered, one cycle behind state):
- At each edge, TX_OUT takes the value for the current state:
  - IDLE: 1
  - START: 0
  - DATA: SER_DATA, sampled before the serializer shifts on the same edge
  - PARITY: par_bit
  - STOP: 1
- Consequence: the line shows a start bit, 8 data bits LSB-first, optional parity, then stop, each exactly 1 CLK.

Outputs and timing:
- BUSY = 1 in every state except IDLE (combinational from state).
- Frame length: 10 CLK without parity, 11 CLK with parity.
- Acceptance-to-start-bit-on-TX_OUT latency: 2 edges.

Simultaneous events and reset:
- SER_DONE and the guard in the same cycle: normal exit, ERR not set.
- SER_DONE outside DATA: ignored.
- RST asserted mid-frame: immediate return to IDLE; TX_OUT = 1; partial frame abandoned; ERR cleared.

Test Plan:
1. Reset, then hold: TX_OUT = 1, BUSY = 0, SER_EN = 0, ERR = 0 for 20 cycles.
2. P_DATA = 8'hA5, PAR_EN = 0, serializer model with SER_DONE on the 8th DATA cycle -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop); SER_EN high exactly 8 cycles; BUSY high 10 cycles.
3. P_DATA = 8'h07, PAR_EN = 1, PAR_TYP = 0 -> parity bit = 1; PAR_TYP = 1 -> parity bit = 0; frame is 11 cycles.
4. Serializer model never raises SER_DONE -> data phase ends after 8 cycles via the guard, frame completes normally, ERR = 1 and stays 1 through the next good frame.
5. DATA_VALID held high continuously -> frames back-to-back with exactly one IDLE cycle (TX_OUT = 1) between stop and start; DATA_VALID pulses mid-frame are ignored.
6. RST pulsed low during the 4th DATA cycle -> same cycle: TX_OUT = 1, BUSY = 0, SER_EN = 0; the next DATA_VALID starts a complete, correct frame.
